// File: rtl/serial_parity_pkg.sv
// Shared types and width helpers for the serial parity shifter.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   // Counter width able to hold 0..data_w inclusive.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

   localparam int DEFAULT_DATA_W = 4;
   localparam int DEFAULT_CNT_W  = cnt_width(DEFAULT_DATA_W);

endpackage

// File: rtl/serial_parity_shifter_ones_accumulator.sv
// Counts ones seen on the serial stream for one word; parity is the count LSB.
module ones_accumulator #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CNT_W-1:0] count,
   output logic             parity
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over a same-cycle increment so a fresh word starts from zero.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CNT_W'(bit_in);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign parity = count_q[0];

endmodule

// File: rtl/serial_parity_shifter.sv
// Serializes each captured word, then emits one parity bit and reports the
// number of ones in the word.
module serial_parity_shifter
   import serial_parity_pkg::*;
#(
   parameter  int DATA_W    = 4,
   parameter  int LSB_FIRST = 1,
   parameter  int ODD_PAR   = 0,
   localparam int CNT_W     = cnt_width(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   input  logic              hold,
   output logic              ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              par_valid,
   output logic [CNT_W-1:0]  ones_count,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]    ones_count_q, ones_count_d;

   logic                cur_bit_s;
   logic                shift_step_s;
   logic                capture_s;
   logic [CNT_W-1:0]    acc_count_s;
   logic                acc_par_s;

   assign cur_bit_s    = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
   assign shift_step_s = (state_q == SHIFT) && !hold;
   assign capture_s    = load && ((state_q == IDLE) || ((state_q == PARITY) && !hold));

   ones_accumulator #(
      .CNT_W (CNT_W)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (capture_s),
      .en     (shift_step_s),
      .bit_in (cur_bit_s),
      .count  (acc_count_s),
      .parity (acc_par_s)
   );

   // Next-state logic for the FSM, shift register and completed-word count.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_idx_d    = bit_idx_q;
      ones_count_d = ones_count_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               shreg_d   = data_in;
               bit_idx_d = '0;
               state_d   = SHIFT;
            end else begin
               state_d   = IDLE;
            end
         end
         SHIFT: begin
            if (!hold) begin
               if (LSB_FIRST != 0) begin
                  shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
               end else begin
                  shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               end
               bit_idx_d = bit_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (bit_idx_q == CNT_W'(DATA_W - 1)) begin
                  state_d = PARITY;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = SHIFT;
            end
         end
         PARITY: begin
            // A load during hold is dropped here; upstream keeps it asserted.
            if (!hold) begin
               ones_count_d = acc_count_s;
               if (load) begin
                  shreg_d   = data_in;
                  bit_idx_d = '0;
                  state_d   = SHIFT;
               end else begin
                  state_d   = IDLE;
               end
            end else begin
               state_d = PARITY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_idx_q    <= '0;
         ones_count_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_idx_q    <= bit_idx_d;
         ones_count_q <= ones_count_d;
      end
   end

   assign ready      = (state_q == IDLE) || (state_q == PARITY);
   assign busy       = (state_q == SHIFT) || (state_q == PARITY);
   assign ser_valid  = (state_q == SHIFT) && !hold;
   assign par_valid  = (state_q == PARITY) && !hold;
   assign ser_out    = (state_q == SHIFT)  ? cur_bit_s :
                       (state_q == PARITY) ? (acc_par_s ^ (ODD_PAR != 0)) : 1'b0;
   // The word's count is visible during its own parity cycle, then held.
   assign ones_count = (state_q == PARITY) ? acc_count_s : ones_count_q;

endmodule

// File: tb/tb_serial_parity_shifter.sv
// Self-checking bench: an LSB-first/even instance (A) and an MSB-first/odd
// instance (B), checked by hand-computed vectors and a word-level random model.
module tb_serial_parity_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] data_in = 4'd0;
   logic       load = 1'b0;
   logic       hold = 1'b0;
   logic       cur_sel = 1'b0;
   logic       load_a, load_b;

   logic       rdy_a, so_a, sv_a, pv_a, bsy_a;
   logic       rdy_b, so_b, sv_b, pv_b, bsy_b;
   logic [2:0] cnt_a, cnt_b;
   logic       rdy, so, sv, pv, bsy;
   logic [2:0] cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign load_a = load & ~cur_sel;
   assign load_b = load & cur_sel;
   assign rdy = cur_sel ? rdy_b : rdy_a;
   assign so  = cur_sel ? so_b  : so_a;
   assign sv  = cur_sel ? sv_b  : sv_a;
   assign pv  = cur_sel ? pv_b  : pv_a;
   assign bsy = cur_sel ? bsy_b : bsy_a;
   assign cnt = cur_sel ? cnt_b : cnt_a;

   serial_parity_shifter #(.DATA_W(4), .LSB_FIRST(1), .ODD_PAR(0)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .load(load_a), .hold(hold),
      .ready(rdy_a), .ser_out(so_a), .ser_valid(sv_a), .par_valid(pv_a),
      .ones_count(cnt_a), .busy(bsy_a));

   serial_parity_shifter #(.DATA_W(4), .LSB_FIRST(0), .ODD_PAR(1)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in), .load(load_b), .hold(hold),
      .ready(rdy_b), .ser_out(so_b), .ser_valid(sv_b), .par_valid(pv_b),
      .ones_count(cnt_b), .busy(bsy_b));

   typedef struct {
      bit       sel;
      bit [3:0] word;
      bit [3:0] stream;   // bit k = k-th emitted data bit
      bit       par;
      bit [2:0] cnt;
      int       hold_at;
      int       hold_len;
      int       par_hold;
      int       ign_at;
      bit       chain;    // next word is loaded during this word's parity cycle
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input vec_t v);
      cur_sel = v.sel;
      load    = 1'b1;
      data_in = v.word;
      tick();
      load    = 1'b0;
      data_in = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
         if (k == v.hold_at) begin
            for (int h = 0; h < v.hold_len; h++) begin
               hold = 1'b1;
               #1;
               chk("hold_ser_valid", 8'(sv), 8'd0);
               chk("hold_ser_out", 8'(so), 8'(v.stream[k]));
               chk("hold_busy", 8'(bsy), 8'd1);
               tick();
            end
         end
         hold = 1'b0;
         load = (k == v.ign_at);
         if (load) data_in = 4'hF;
         #1;
         chk("data_ser_out", 8'(so), 8'(v.stream[k]));
         chk("data_ser_valid", 8'(sv), 8'd1);
         chk("data_ready", 8'(rdy), 8'd0);
         chk("data_par_valid", 8'(pv), 8'd0);
         tick();
         load = 1'b0;
      end
      for (int h = 0; h < v.par_hold; h++) begin
         hold    = 1'b1;
         load    = 1'b1;
         data_in = 4'($urandom);
         #1;
         chk("phold_par_valid", 8'(pv), 8'd0);
         chk("phold_ser_out", 8'(so), 8'(v.par));
         chk("phold_ready", 8'(rdy), 8'd1);
         tick();
      end
      hold = 1'b0;
      load = 1'b0;
      #1;
      chk("par_valid", 8'(pv), 8'd1);
      chk("par_bit", 8'(so), 8'(v.par));
      chk("par_count", 8'(cnt), 8'(v.cnt));
      chk("par_ready", 8'(rdy), 8'd1);
      chk("par_busy", 8'(bsy), 8'd1);
      chk("par_ser_valid", 8'(sv), 8'd0);
      if (!v.chain) begin
         tick();
         #1;
         chk("idle_busy", 8'(bsy), 8'd0);
         chk("idle_ready", 8'(rdy), 8'd1);
         chk("idle_valids", 8'({sv, pv}), 8'd0);
         chk("idle_count_held", 8'(cnt), 8'(v.cnt));
         chk("idle_ser_out", 8'(so), 8'd0);
      end
   endtask

   // Word-level reference: emission order and parity from the word alone.
   function automatic vec_t model(input bit sel, input bit [3:0] word);
      vec_t v;
      int   ones;
      ones = $countones(word);
      v.sel = sel;
      v.word = word;
      for (int k = 0; k < 4; k++) v.stream[k] = sel ? word[3-k] : word[k];
      v.cnt = 3'(ones);
      v.par = (ones % 2 == 1) ^ sel;
      v.hold_at = -1; v.hold_len = 0; v.par_hold = 0; v.ign_at = -1; v.chain = 1'b0;
      return v;
   endfunction

   initial begin
      tbl[0] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 3'd3, -1, 0, 0, -1, 1'b0};
      tbl[1] = '{1'b1, 4'b0110, 4'b0110, 1'b1, 3'd2, -1, 0, 0, -1, 1'b0};
      tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 3'd1, -1, 0, 0, -1, 1'b1};
      tbl[3] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 3'd4, -1, 0, 0, -1, 1'b0};
      tbl[4] = '{1'b0, 4'b1001, 4'b1001, 1'b0, 3'd2,  2, 3, 0, -1, 1'b0};
      tbl[5] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, -1, 0, 0,  1, 1'b0};
      tbl[6] = '{1'b1, 4'b1100, 4'b0011, 1'b1, 3'd2, -1, 0, 2, -1, 1'b0};
      tbl[7] = '{1'b1, 4'b1110, 4'b0111, 1'b0, 3'd3,  0, 1, 1, -1, 1'b0};

      #2;
      chk("rst_ready", 8'(rdy_a), 8'd1);
      chk("rst_outs", 8'({so_a, sv_a, pv_a, bsy_a}), 8'd0);
      chk("rst_count", 8'(cnt_a), 8'd0);
      #10 rst = 1'b0;
      tick();

      // Reset in the middle of a word.
      cur_sel = 1'b0;
      load = 1'b1; data_in = 4'b1111;
      tick();
      load = 1'b0;
      tick();
      #1;
      chk("pre_rst_busy", 8'(bsy), 8'd1);
      rst = 1'b1;
      #1;
      chk("midrst_ready", 8'(rdy), 8'd1);
      chk("midrst_valids", 8'({sv, pv}), 8'd0);
      chk("midrst_count", 8'(cnt), 8'd0);
      chk("midrst_busy", 8'(bsy), 8'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_word(tbl[i]);

      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 30; n++) begin
            vec_t v;
            v = model(s[0], 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
               v.hold_at  = int'($urandom_range(0, 3));
               v.hold_len = int'($urandom_range(1, 3));
            end
            v.par_hold = int'($urandom_range(0, 3)) == 0 ? 1 : 0;
            v.ign_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            v.chain    = (n != 29) && ($urandom_range(0, 1) == 1);
            run_word(v);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
